seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 8, number of multiplexed digits (1..8).
REQ-002 Parameter DATA_W, default 32, width of displayed value (4..32).
REQ-003 Parameter SCAN_DIV, default 50000, clk_in cycles per digit slot (>=2).
REQ-004 Port clk_in  input  1  single system clock; all logic on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port data_in  input  DATA_W  value to display, sampled on load.
REQ-007 Port load  input  1  capture request, single-cycle pulse.
REQ-008 Port mode_dec  input  1  sampled with load: 0 = hex, 1 = unsigned decimal.
REQ-009 Port blank_lz  input  1  live: 1 = blank leading zero digits.
REQ-010 Port o_seg  output  8  {dp,g,f,e,d,c,b,a}, active low, registered.
REQ-011 Port o_sel  output  DIGITS  one-hot-low digit enable, registered.
REQ-012 Port busy  output  1  capture/conversion in progress.
REQ-013 Port conv_done  output  1  one-cycle pulse when display buffer is updated.
REQ-014 Port ovf  output  1  last decimal value exceeded 10^DIGITS-1.

Function
REQ-015 Capture FSM states: IDLE, SHIFT, DONE; reset to IDLE.
REQ-016 IDLE with load=1: latch data_in and mode_dec; hex goes to DONE, decimal goes to SHIFT.
REQ-017 SHIFT: shift-add-3 conversion of DATA_W bits, MSB first, one bit per cycle, into a 4*DIGITS-bit BCD register; exactly DATA_W cycles, then DONE.
REQ-018 DONE: write display buffer, conv_done=1 for that cycle only, return to IDLE.
REQ-019 Load in cycle t: hex DONE at t+1; decimal SHIFT t+1..t+DATA_W, DONE at t+DATA_W+1.
REQ-020 busy=1 in SHIFT and DONE; load while busy is ignored, with no queuing.
REQ-021 Hex buffer = low 4*DIGITS bits of the value, zero-extended if DATA_W < 4*DIGITS; ovf cleared.
REQ-022 Decimal buffer = value mod 10^DIGITS; ovf = sticky OR of bits shifted out of the top BCD digit during that conversion, updated in DONE.
REQ-023 Display shows the old buffer unchanged until DONE.
REQ-024 Prescaler counts 0..SCAN_DIV-1 and wraps; at terminal count, digit index advances (DIGITS-1 wraps to 0).
REQ-025 Outputs register the current index: o_sel = ~(1<<idx); o_seg = pattern of buffer digit idx; dp (bit 7) always 1.
REQ-026 Patterns 0..F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
REQ-027 blank_lz=1: digit i>0 shows o_seg=FF when digits i..DIGITS-1 are all zero; digit 0 is never blanked; applies in both modes.

Reset
REQ-028 reset=1 in any state, including mid-SHIFT: FSM IDLE, prescaler 0, idx 0, buffer 0, BCD register 0, busy 0, conv_done 0, ovf 0, o_seg FF, o_sel all ones.
REQ-029 First edge after reset release: o_sel = ~1 and o_seg = C0 (blank_lz has no effect on digit 0).
REQ-030 A conversion aborted by reset never updates the buffer and never pulses conv_done.

Verification (DIGITS=4, DATA_W=16, SCAN_DIV=4)
REQ-031 Hex 0xBEEF load -> conv_done at t+1; over one scan round, idx0..3 show 8E,86,86,83 with o_sel E,D,B,7.
REQ-032 Decimal 1234 load -> busy for 17 cycles, conv_done at t+17; digits 99,B0,A4,F9; ovf=0.
REQ-033 Decimal 65535 -> digits show 5535 (92,B0,92,92); ovf=1. A following hex load clears ovf.
REQ-034 Decimal 7 with blank_lz=1 -> idx0 F8, idx1..3 FF. Value 0 -> idx0 C0, others FF.
REQ-035 Load 0x0001 issued during SHIFT -> ignored; buffer holds the first result; exactly one conv_done.
REQ-036 Reset at t+8 of a decimal conversion -> outputs per REQ-028; no conv_done; display 0 after release.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: captures a value as hex or decimal (shift-add-3),
// then scans the stored digits with active-low segment/select outputs.
module seg7_scan_driver #(
   parameter int unsigned DIGITS   = 8,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   input  logic              mode_dec,
   input  logic              blank_lz,
   output logic [7:0]        o_seg,
   output logic [DIGITS-1:0] o_sel,
   output logic              busy,
   output logic              conv_done,
   output logic              ovf
);

   localparam int unsigned BCD_W  = 4 * DIGITS;
   localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
   localparam int unsigned CNT_W  = $clog2(DATA_W);
   localparam int unsigned WIDE_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               mode_q, mode_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               acc_q, acc_d;
   logic [BCD_W-1:0]   buf_q, buf_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [7:0]         seg_q, seg_d;
   logic [DIGITS-1:0]  sel_q, sel_d;

   logic [BCD_W-1:0]   adj;
   logic [WIDE_W-1:0]  hex_wide;
   logic [3:0]         cur_digit;
   logic               hi_zero;

   function automatic logic [7:0] seg_pat(input logic [3:0] d);
      logic [7:0] p;
      case (d)
         4'h0: p = 8'hC0;
         4'h1: p = 8'hF9;
         4'h2: p = 8'hA4;
         4'h3: p = 8'hB0;
         4'h4: p = 8'h99;
         4'h5: p = 8'h92;
         4'h6: p = 8'h82;
         4'h7: p = 8'hF8;
         4'h8: p = 8'h80;
         4'h9: p = 8'h90;
         4'hA: p = 8'h88;
         4'hB: p = 8'h83;
         4'hC: p = 8'hC6;
         4'hD: p = 8'hA1;
         4'hE: p = 8'h86;
         default: p = 8'h8E;
      endcase
      return p;
   endfunction

   // Capture FSM and shift-add-3 datapath
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      bcd_d    = bcd_q;
      acc_d    = acc_q;
      buf_d    = buf_q;
      ovf_d    = ovf_q;
      hex_wide = WIDE_W'(data_q);
      adj      = bcd_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end

      case (state_q)
         IDLE: begin
            if (load) begin
               data_d  = data_in;
               mode_d  = mode_dec;
               cnt_d   = '0;
               bcd_d   = '0;
               acc_d   = 1'b0;
               state_d = mode_dec ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            // Top adjusted bit falls off the register; remember it as overflow
            bcd_d  = {adj[BCD_W-2:0], data_q[DATA_W-1]};
            acc_d  = acc_q | adj[BCD_W-1];
            data_d = data_q << 1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
         end
         DONE: begin
            buf_d   = mode_q ? bcd_q : hex_wide[BCD_W-1:0];
            ovf_d   = mode_q & acc_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // Scan prescaler, digit index and registered segment/select drive
   always_comb begin
      pre_d = pre_q + PRE_W'(1);
      idx_d = idx_q;
      if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end

      cur_digit = 4'd0;
      hi_zero   = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (IDX_W'(i) == idx_q) cur_digit = buf_q[4*i +: 4];
         if ((IDX_W'(i) >= idx_q) && (buf_q[4*i +: 4] != 4'd0)) hi_zero = 1'b0;
      end

      seg_d = (blank_lz && (idx_q != '0) && hi_zero) ? 8'hFF : seg_pat(cur_digit);
      sel_d = ~(DIGITS'(1) << idx_q);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         acc_q   <= 1'b0;
         buf_q   <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pre_q   <= '0;
         idx_q   <= '0;
         seg_q   <= 8'hFF;
         sel_q   <= '1;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         acc_q   <= acc_d;
         buf_q   <= buf_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         sel_q   <= sel_d;
      end
   end

   assign o_seg     = seg_q;
   assign o_sel     = sel_q;
   assign busy      = busy_q;
   assign conv_done = done_q;
   assign ovf       = ovf_q;

endmodule
